// File: rtl/mem_responder.sv
// Word-addressed memory responder with a Req/Ack handshake and parameterised read/write wait states.
// Optional byte-lane write enables are enabled by defining MEM_RESPONDER_BYTE_WRITE_EN.
module mem_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] Datain,
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
  input  logic [3:0]  ByteEn,
`endif
  output logic [31:0] Dataout,
  output logic        Ack,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [2:0] RD_CNT = 3'(READ_LATENCY - 1);
  localparam logic [2:0] WR_CNT = 3'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            wr_q;
  logic [31:0]     addr_q, data_q;
  logic            err_q;
  logic [31:0]     dout_q;
  logic [3:0]      be_q;
  logic [31:0]     mem [DEPTH];

  // The transaction being finished: straight from the inputs when the accept edge is also the commit edge.
  logic                  cur_wr;
  logic [31:0]           cur_addr, cur_data;
  logic [3:0]            cur_be;
  logic                  cur_err;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic                  enter_resp;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          cnt_d   = Wr ? WR_CNT : RD_CNT;
          state_d = (cnt_d == 3'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_wr   = (state_q == S_IDLE) ? Wr      : wr_q;
    cur_addr = (state_q == S_IDLE) ? Address : addr_q;
    cur_data = (state_q == S_IDLE) ? Datain  : data_q;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    cur_be   = (state_q == S_IDLE) ? ByteEn  : be_q;
`else
    cur_be   = 4'hF;
`endif
    cur_err    = (cur_addr[1:0] != 2'b00) || (|cur_addr[31:ADDR_WIDTH+2]);
    cur_idx    = cur_addr[ADDR_WIDTH+1:2];
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP) && !Reset;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && Req) begin
        wr_q   <= Wr;
        addr_q <= Address;
        data_q <= Datain;
        be_q   <= cur_be;
      end
      if (enter_resp) begin
        err_q <= cur_err;
        if (!cur_wr && !cur_err) dout_q <= mem[cur_idx];
      end
    end
  end

  // NOTE: the store is deliberately left out of reset; contents survive Reset and need no reset fan-out.
  always_ff @(posedge Clk) begin
    if (enter_resp && cur_wr && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
      end
    end
  end

  assign Ack     = (state_q == S_RESP);
  assign Busy    = (state_q != S_IDLE);
  assign AddrErr = Ack && err_q;
  assign Dataout = dout_q;

endmodule
